// File: rtl/conv_window_feeder_if.sv
// Handshake and beat bus of the convolution window feeder.
// master = producer/consumer side, slave = the feeder itself.
interface conv_window_feeder_if #(
  parameter int DW = 6
);
  logic          reload;
  logic          wgt_valid;
  logic [DW-1:0] wgt_data;
  logic          wgt_ready;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic          smp_ready;
  logic          out_en;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic          win_done;
  logic [15:0]   win_cnt;

  modport master (
    output reload, wgt_valid, wgt_data, smp_valid, smp_data,
    input  wgt_ready, smp_ready, out_en, out_data, out_sel, win_done, win_cnt
  );
  modport slave (
    input  reload, wgt_valid, wgt_data, smp_valid, smp_data,
    output wgt_ready, smp_ready, out_en, out_data, out_sel, win_done, win_cnt
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Forwards kernel weights as beats, then replays sliding sample windows
// (oldest first) as TAPS-beat streams with a per-window done pulse.
module conv_window_feeder #(
  parameter int DW     = 6,
  parameter int TAPS   = 4,
  parameter int STRIDE = 1
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_feeder_if.slave bus
);
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);
  localparam logic [CW-1:0] LAST_STR = CW'(STRIDE - 1);

  localparam logic [1:0] LOAD_W = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] EMIT   = 2'd2;
  localparam logic [1:0] SLIDE  = 2'd3;

  logic [1:0]                 state;
  logic [CW-1:0]              cnt;
  logic [TAPS-1:0][DW-1:0]    win;
  logic [TAPS-1:0][DW-1:0]    win_sh;
  logic                       reload_q;
  logic                       reload_now;
  logic                       wgt_acc;
  logic                       smp_acc;
  logic [CW-1:0]              smp_last;

  // Newest sample enters at the top; index 0 is always the oldest.
  assign win_sh     = {bus.smp_data, win[TAPS-1:1]};
  assign reload_now = reload_q | bus.reload;
  assign wgt_acc    = bus.wgt_valid & bus.wgt_ready;
  assign smp_acc    = bus.smp_valid & bus.smp_ready;
  assign smp_last   = (state == FILL) ? LAST_TAP : LAST_STR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD_W;
      cnt           <= '0;
      win           <= '0;
      reload_q      <= 1'b0;
      bus.wgt_ready <= 1'b0;
      bus.smp_ready <= 1'b0;
      bus.out_en    <= 1'b0;
      bus.out_sel   <= 1'b0;
      bus.out_data  <= '0;
      bus.win_done  <= 1'b0;
      bus.win_cnt   <= '0;
    end else begin
      bus.out_en   <= 1'b0;
      bus.out_sel  <= 1'b0;
      bus.win_done <= 1'b0;
      reload_q     <= reload_now;
      case (state)
        LOAD_W: begin
          reload_q      <= 1'b0;
          bus.wgt_ready <= 1'b1;
          bus.smp_ready <= 1'b0;
          if (wgt_acc) begin
            bus.out_en   <= 1'b1;
            bus.out_sel  <= 1'b1;
            bus.out_data <= bus.wgt_data;
            if (cnt == LAST_TAP) begin
              cnt           <= '0;
              state         <= FILL;
              bus.wgt_ready <= 1'b0;
              bus.smp_ready <= 1'b1;
              bus.win_cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FILL, SLIDE: begin
          // A pending reload discards any partially gathered samples.
          if (reload_now) begin
            state         <= LOAD_W;
            cnt           <= '0;
            reload_q      <= 1'b0;
            bus.smp_ready <= 1'b0;
            bus.wgt_ready <= 1'b1;
            bus.win_cnt   <= '0;
          end else if (smp_acc) begin
            win <= win_sh;
            if (cnt == smp_last) begin
              cnt           <= '0;
              state         <= EMIT;
              bus.smp_ready <= 1'b0;
              bus.out_en    <= 1'b1;
              bus.out_data  <= win_sh[0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin  // EMIT: cnt is the beat currently on the bus
          if (cnt == LAST_TAP) begin
            cnt          <= '0;
            bus.win_done <= 1'b1;
            if (reload_now) begin
              state         <= LOAD_W;
              reload_q      <= 1'b0;
              bus.wgt_ready <= 1'b1;
              bus.win_cnt   <= '0;
            end else begin
              state         <= SLIDE;
              bus.smp_ready <= 1'b1;
              bus.win_cnt   <= bus.win_cnt + 16'd1;
            end
          end else begin
            cnt          <= cnt + 1'b1;
            bus.out_en   <= 1'b1;
            bus.out_data <= win[cnt + 1'b1];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: inputs driven and outputs sampled on negedge.
module tb_conv_window_feeder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_feeder_if #(.DW(6)) u_if();
  conv_window_feeder #(.DW(6), .TAPS(4), .STRIDE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Weights base..base+3, each forwarded as a sel=1 beat the cycle after acceptance.
  task automatic load_w(input logic [5:0] base);
    logic [5:0] ew;
    for (int i = 0; i < 4; i++) begin
      u_if.wgt_valid = 1'b1;
      u_if.wgt_data  = base + 6'(i);
      ew = base + 6'(i);
      tick();
      chk("wgt_beat_en",  u_if.out_en,  1'b1);
      chk("wgt_beat_sel", u_if.out_sel, 1'b1);
      n_chk++;
      if (u_if.out_data === ew) n_pass++;
      else $error("FAIL wgt_beat_data: got 0x%0h expected 0x%0h", u_if.out_data, ew);
    end
    u_if.wgt_valid = 1'b0;
    chk("fill_wgt_ready", u_if.wgt_ready, 1'b0);
    chk("fill_smp_ready", u_if.smp_ready, 1'b1);
  endtask

  // Four samples base..base+3, optionally with a bubble before each.
  task automatic fill(input logic [5:0] base, input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        u_if.smp_valid = 1'b0;
        tick();
        chk("fill_gap_ready", u_if.smp_ready, 1'b1);
        chk("fill_gap_en",    u_if.out_en,    1'b0);
      end
      u_if.smp_valid = 1'b1;
      u_if.smp_data  = base + 6'(i);
      tick();
      if (i < 3) chk("fill_no_beat", u_if.out_en, 1'b0);
    end
    u_if.smp_valid = 1'b0;
  endtask

  // Called with beat 0 already on the bus; ends on the win_done cycle.
  task automatic emit_check(input logic [5:0] w0, w1, w2, w3,
                            input logic [15:0] ecnt, input int rl_beat);
    logic [5:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("emit_en",    u_if.out_en,    1'b1);
      chk("emit_sel",   u_if.out_sel,   1'b0);
      n_chk++;
      if (u_if.out_data === w[k]) n_pass++;
      else $error("FAIL emit_data: got 0x%0h expected 0x%0h", u_if.out_data, w[k]);
      chk("emit_ready",  u_if.smp_ready, 1'b0);
      chk("emit_nodone", u_if.win_done,  1'b0);
      u_if.smp_valid = ~u_if.smp_valid;
      u_if.reload    = (k == rl_beat);
    end
    u_if.reload    = 1'b0;
    u_if.smp_valid = 1'b0;
    tick();
    chk("done_pulse", u_if.win_done, 1'b1);
    chk("done_en",    u_if.out_en,   1'b0);
    chk("done_sel",   u_if.out_sel,  1'b0);
    chk("done_hold",  u_if.out_data, w3);
    chk("done_cnt",   u_if.win_cnt,  ecnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    u_if.reload = 1'b0; u_if.wgt_valid = 1'b0; u_if.wgt_data = '0;
    u_if.smp_valid = 1'b0; u_if.smp_data = '0;
    tick();
    chk("rst_out_en",    u_if.out_en,    1'b0);
    chk("rst_out_data",  u_if.out_data,  6'd0);
    chk("rst_wgt_ready", u_if.wgt_ready, 1'b0);
    chk("rst_smp_ready", u_if.smp_ready, 1'b0);
    chk("rst_win_done",  u_if.win_done,  1'b0);
    chk("rst_win_cnt",   u_if.win_cnt,   16'd0);
    rst = 1'b0;
    tick();
    chk("loadw_ready", u_if.wgt_ready, 1'b1);

    load_w(6'd1);
    fill(6'd10, 1'b0);
    emit_check(6'd10, 6'd11, 6'd12, 6'd13, 16'd1, -1);
    chk("slide_ready", u_if.smp_ready, 1'b1);
    u_if.smp_valid = 1'b1; u_if.smp_data = 6'd14;
    tick();
    u_if.smp_valid = 1'b0;
    emit_check(6'd11, 6'd12, 6'd13, 6'd14, 16'd2, -1);
    tick();
    chk("stall_ready", u_if.smp_ready, 1'b1);
    chk("stall_en",    u_if.out_en,    1'b0);
    chk("stall_cnt",   u_if.win_cnt,   16'd2);

    u_if.smp_valid = 1'b1; u_if.smp_data = 6'd15;
    tick();
    u_if.smp_valid = 1'b0;
    emit_check(6'd12, 6'd13, 6'd14, 6'd15, 16'd0, 1);
    chk("reload_wgt_ready", u_if.wgt_ready, 1'b1);
    chk("reload_smp_ready", u_if.smp_ready, 1'b0);
    load_w(6'd5);
    fill(6'd10, 1'b1);
    emit_check(6'd10, 6'd11, 6'd12, 6'd13, 16'd1, -1);
    u_if.smp_valid = 1'b0;
    tick();
    u_if.smp_valid = 1'b1; u_if.smp_data = 6'd14;
    tick();
    u_if.smp_valid = 1'b0;
    emit_check(6'd11, 6'd12, 6'd13, 6'd14, 16'd2, -1);

    u_if.smp_valid = 1'b1; u_if.smp_data = 6'd15;
    tick();
    u_if.smp_valid = 1'b0;
    chk("pre_rst_beat0", u_if.out_data, 6'd12);
    tick();
    chk("pre_rst_beat1", u_if.out_data, 6'd13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_en",   u_if.out_en,   1'b0);
    chk("abort_done", u_if.win_done, 1'b0);
    chk("abort_cnt",  u_if.win_cnt,  16'd0);
    tick();
    chk("abort_loadw",  u_if.wgt_ready, 1'b1);
    chk("abort_nodone", u_if.win_done,  1'b0);
    chk("abort_noen",   u_if.out_en,    1'b0);

    load_w(6'd1);
    u_if.smp_valid = 1'b1; u_if.smp_data = 6'd40;
    tick();
    u_if.smp_data = 6'd41;
    tick();
    u_if.smp_valid = 1'b0; u_if.reload = 1'b1;
    tick();
    u_if.reload = 1'b0;
    chk("fill_reload_wgt", u_if.wgt_ready, 1'b1);
    chk("fill_reload_smp", u_if.smp_ready, 1'b0);
    load_w(6'd1);
    fill(6'd20, 1'b0);
    emit_check(6'd20, 6'd21, 6'd22, 6'd23, 16'd1, -1);

    force u_if.win_cnt = 16'hFFFF;
    tick();
    release u_if.win_cnt;
    tick();
    chk("preset_cnt", u_if.win_cnt, 16'hFFFF);
    u_if.smp_valid = 1'b1; u_if.smp_data = 6'd24;
    tick();
    u_if.smp_valid = 1'b0;
    emit_check(6'd21, 6'd22, 6'd23, 6'd24, 16'd0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
